fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
Sequences the IF stage of the 5-stage pipeline. Owns the fetch PC and drives a single-outstanding req/ack instruction-memory port. Delivers InstrD/PCD/PCPlus4D with a ValidD qualifier to decode, honouring decode stall (StallF) and execute-stage redirect (PCSrcE/PCTargetE). Sits between the hazard unit, the execute stage and instruction memory.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
NOP_INSTR, 32'h00000013, value driven on InstrD when no valid instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
PCSrcE  in  1  redirect request from execute (branch/jump taken)
PCTargetE  in  32  redirect target; bits [1:0] forced to 0 internally
StallF  in  1  decode cannot accept a new instruction this cycle
imem_req  out  1  memory request, held until imem_ack
imem_addr  out  32  word-aligned fetch address, stable while imem_req=1 and not acked
imem_ack  in  1  transfer complete; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
InstrD  out  32  instruction to decode (registered)
PCD  out  32  PC of InstrD
PCPlus4D  out  32  PCD + 4, modulo 2^32
ValidD  out  1  InstrD/PCD/PCPlus4D hold a real instruction
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at posedge, overrides everything, including mid-transfer): state=IDLE, imem_req=0, imem_addr=RESET_PC, fetch pc=RESET_PC, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, skid buffer empty. The in-flight memory access is abandoned; memory must tolerate this.
- States: IDLE, REQ, DROP, HOLD.
- IDLE: one cycle after reset release -> REQ, imem_req=1, imem_addr=pc.
- REQ: imem_req=1. On imem_ack with no redirect:
  - If decode accepts (!StallF or !ValidD): D regs <= {imem_rdata, imem_addr, imem_addr+4}, ValidD=1, imem_addr <= imem_addr+4, stay in REQ. A memory acking every cycle yields 1 instr/cycle.
  - If StallF && ValidD: store into a 1-entry skid buffer, imem_req <= 0, -> HOLD.
- No ack and StallF && ValidD: D regs unchanged.
- HOLD: imem_req=0. When StallF=0: buffer -> D regs, ValidD=1, imem_req=1, imem_addr = buffered PC+4, -> REQ.
- Redirect (PCSrcE=1 at posedge), any state except IDLE:
  - ValidD <= 0, InstrD <= NOP_INSTR, buffer cleared.
  - pc <= {PCTargetE[31:2],2'b00}.
  - REQ without ack: address cannot change before ack, so -> DROP, keep imem_req/imem_addr.
  - REQ with simultaneous ack, or HOLD: data discarded; next cycle imem_req=1, imem_addr=target, state REQ.
- DROP: on imem_ack, discard data; -> REQ, imem_addr=pc. A further redirect in DROP overwrites pc (last wins).
- Redirect has priority over StallF. A redirect in IDLE only updates pc.
- PC arithmetic wraps: 32'hFFFFFFFC + 4 = 32'h00000000.
- ValidD=0 forces decode acceptance regardless of StallF.

Optional Feature:
FETCH_PERF_EN: when defined, adds outputs perf_fetched[31:0] and perf_stall[31:0], both reset to 0 and wrapping.
- perf_fetched increments on each instruction written to the D regs.
- perf_stall increments on each cycle with imem_req=1 and imem_ack=0, or state=HOLD.
When undefined, these ports and their logic are absent.

Decomposition:
- Package fetch_pkg: state enum fetch_state_t {IDLE,REQ,DROP,HOLD}, NOP_INSTR constant, typedef fetch_pkt_t {instr, pc, pc_plus4}.
- Sub-module fetch_skid_buf: 1-entry fetch_pkt_t buffer with load/clear/valid. It is natural to separate out.

Test Plan:
- Reset, 1-cycle-ack memory returning addr-derived data, StallF=0 -> imem_addr 0,4,8…; ValidD first high 2 cycles after req; PCD=0, PCPlus4D=4.
- StallF=1 for 3 cycles while ack returns addr 8 -> HOLD, imem_req=0, PCD stays 4; after release PCD=8, then req addr 12.
- PCSrcE=1, PCTargetE=32'h00000101 while waiting on a 3-cycle ack -> DROP, stale data never reaches ValidD; next req addr 32'h00000100.
- Redirect in the same cycle as ack -> data discarded, ValidD=0 next cycle, next imem_addr=target.
- rst asserted mid-transfer in DROP -> all outputs at reset values next cycle; first req at RESET_PC.
- pc=32'hFFFFFFFC fetched -> PCPlus4D=0, next imem_addr=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_t : fetch controller states
//   NOP_INSTR     : filler instruction presented to decode when nothing is valid
//   fetch_pkt_t   : one fetched instruction with its PC and PC+4
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } fetch_pkt_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction that arrived while decode was stalled.
//   clk, rst : clock and synchronous active-high reset
//   load     : capture din
//   clear    : empty the buffer (wins over load)
//   din      : packet to capture
//   dout     : stored packet
//   valid    : buffer holds a packet
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       clear,
    input  fetch_pkt_t din,
    output fetch_pkt_t dout,
    output logic       valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns the fetch PC, drives a single-outstanding req/ack
// instruction-memory port and presents registered InstrD/PCD/PCPlus4D/ValidD to decode.
//   clk, rst             : clock, synchronous active-high reset
//   PCSrcE, PCTargetE    : execute-stage redirect and its target
//   StallF               : decode cannot accept a new instruction
//   imem_req/addr        : memory request and word address (stable until ack)
//   imem_ack/rdata       : memory completion and returned instruction
//   InstrD/PCD/PCPlus4D  : decode-stage instruction and PCs, qualified by ValidD
//   busy                 : controller has left IDLE
// Optional: define FETCH_PERF_EN to add perf_fetched / perf_stall counters.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    fetch_pkt_t   d_q, d_d;
    logic         valid_q, valid_d;

    logic         buf_load, buf_clear, buf_valid;
    fetch_pkt_t   buf_pkt, fetched;
    logic         accept;
    logic [31:0]  target;

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (fetched),
        .dout  (buf_pkt),
        .valid (buf_valid)
    );

    // Decode takes the current D contents this cycle (or there is nothing to take).
    assign accept  = !valid_q || !StallF;
    assign target  = align_word(PCTargetE);
    assign fetched = '{instr: imem_rdata, pc: addr_q, pc_plus4: addr_q + 32'd4};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        d_d       = d_q;
        valid_d   = valid_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;

        if (accept) begin
            valid_d   = 1'b0;
            d_d.instr = NOP_INSTR;
        end

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                pc_d    = PCSrcE ? target : pc_q;
                addr_d  = PCSrcE ? target : pc_q;
            end
            REQ: begin
                if (PCSrcE) begin
                    pc_d = target;
                    // Address must stay put until the pending access completes.
                    if (imem_ack) addr_d = target;
                    else          state_d = DROP;
                end else if (imem_ack) begin
                    addr_d = addr_q + 32'd4;
                    pc_d   = addr_q + 32'd4;
                    if (accept) begin
                        d_d     = fetched;
                        valid_d = 1'b1;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            DROP: begin
                if (PCSrcE) pc_d = target;
                if (imem_ack) begin
                    state_d = REQ;
                    addr_d  = PCSrcE ? target : pc_q;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pc_d    = target;
                    addr_d  = target;
                    state_d = REQ;
                end else if (!StallF && buf_valid) begin
                    d_d       = buf_pkt;
                    valid_d   = 1'b1;
                    addr_d    = buf_pkt.pc_plus4;
                    pc_d      = buf_pkt.pc_plus4;
                    buf_clear = 1'b1;
                    state_d   = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect squashes whatever sits in D and in the skid buffer.
        if (PCSrcE && state_q != IDLE) begin
            valid_d   = 1'b0;
            d_d.instr = NOP_INSTR;
            buf_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            d_q     <= '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            d_q     <= d_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req  = (state_q == REQ) || (state_q == DROP);
    assign imem_addr = addr_q;
    assign InstrD    = d_q.instr;
    assign PCD       = d_q.pc;
    assign PCPlus4D  = d_q.pc_plus4;
    assign ValidD    = valid_q;
    assign busy      = (state_q != IDLE);

`ifdef FETCH_PERF_EN
    logic wrote;

    assign wrote = !PCSrcE &&
                   (((state_q == REQ) && imem_ack && accept) ||
                    ((state_q == HOLD) && !StallF && buf_valid));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (wrote) perf_fetched <= perf_fetched + 32'd1;
            if ((imem_req && !imem_ack) || (state_q == HOLD)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller. The reference is the architectural
// instruction stream: after reset or a redirect, decode must see consecutive
// word addresses starting at the new PC, each carrying the memory word for that
// address. The stimulus process pushes that stream into a queue; the monitor pops
// one entry each time decode consumes a valid instruction.
module tb_fetch_controller;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h00000000;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam int          NCYC   = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'd0;
    logic        StallF = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD, busy;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    fetch_controller dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .StallF     (StallF),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .busy       (busy)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int consumed    = 0;
    int idle_cycles = 0;

    fetch_pkt_t exp_q[$];
    logic [31:0] base_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        base_pc = pc & ~32'd3;
    endtask

    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{instr: mem_word(base_pc), pc: base_pc, pc_plus4: base_pc + 32'd4});
            base_pc = base_pc + 32'd4;
        end
    endtask

    // Memory: random 0..3 cycle latency, checks the request is held and stable.
    initial begin
        logic        m_active = 1'b0;
        logic [31:0] m_addr = 32'd0;
        int          m_cnt = 0;
        logic        r, a;
        forever begin
            @(posedge clk);
            r = rst;
            a = imem_ack;
            #1;
            imem_rdata = $urandom;
            if (r) begin
                m_active = 1'b0;
                imem_ack = 1'b0;
            end else begin
                if (a) begin
                    m_active = 1'b0;
                    imem_ack = 1'b0;
                end
                if (imem_req) begin
                    if (!m_active) begin
                        m_active = 1'b1;
                        m_addr   = imem_addr;
                        m_cnt    = $urandom_range(0, 3);
                    end else begin
                        check32("imem_addr_stable", imem_addr, m_addr);
                    end
                    if (m_cnt == 0) begin
                        imem_ack   = 1'b1;
                        imem_rdata = mem_word(m_addr);
                    end else begin
                        m_cnt--;
                    end
                end else if (m_active) begin
                    check32("imem_req_held", {31'd0, imem_req}, 32'd1);
                    m_active = 1'b0;
                end
            end
        end
    end

    // Monitor: runs on the falling edge, inputs are stable for the coming rising edge.
    initial begin
        fetch_pkt_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!ValidD) check32("nop_when_invalid", InstrD, NOP);
                if (ValidD && !StallF && !PCSrcE) begin
                    idle_cycles = 0;
                    consumed++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL scoreboard_empty: got PCD %h expected no instruction", PCD);
                    end else begin
                        e = exp_q.pop_front();
                        check32("PCD", PCD, e.pc);
                        check32("InstrD", InstrD, e.instr);
                        check32("PCPlus4D", PCPlus4D, e.pc_plus4);
                    end
                end else begin
                    idle_cycles++;
                    if (idle_cycles > 100) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL progress: got %0d idle cycles expected at most 100",
                                 idle_cycles);
                        idle_cycles = 0;
                    end
                end
            end else begin
                idle_cycles = 0;
            end
        end
    end

    // Stimulus.
    initial begin
        logic just_reset = 1'b0;
        logic [31:0] t;
        restart_stream(RST_PC);
        refill();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            if (rst) begin
                check32("rst_ValidD", {31'd0, ValidD}, 32'd0);
                check32("rst_InstrD", InstrD, NOP);
                check32("rst_PCD", PCD, 32'd0);
                check32("rst_PCPlus4D", PCPlus4D, 32'd0);
                check32("rst_imem_req", {31'd0, imem_req}, 32'd0);
                check32("rst_imem_addr", imem_addr, RST_PC);
                check32("rst_busy", {31'd0, busy}, 32'd0);
                just_reset = 1'b1;
            end else if (just_reset) begin
                check32("first_busy", {31'd0, busy}, 32'd1);
                check32("first_imem_req", {31'd0, imem_req}, 32'd1);
                check32("first_imem_addr", imem_addr, exp_q[0].pc);
                just_reset = 1'b0;
            end

            rst    = (cyc < 3) || ($urandom_range(0, 199) == 0);
            StallF = ($urandom_range(0, 9) < 3);
            PCSrcE = !rst && ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) t = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
            else                           t = 32'($urandom_range(0, 1023));
            PCTargetE = t;
            if (rst)         restart_stream(RST_PC);
            else if (PCSrcE) restart_stream(PCTargetE);
            refill();
        end
        rst    = 1'b0;
        PCSrcE = 1'b0;
        @(negedge clk);
        vectors++;
        if (consumed < 300) begin
            miscompares++;
            $display("FAIL throughput: got %0d instructions expected at least 300", consumed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
